seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
//   Next-generation sequential multiplier: radix-2 shift-add core, WORD_LENGTH-parametrised,
//   runtime signed/unsigned mode, Start/ready handshake, synchronous clear and overflow flag.
//   Sits between operand registers and the result consumer in datapaths where a
//   combinational WORD_LENGTH x WORD_LENGTH array is too large; one product in flight at a time.
// PARAMETERS
//   WORD_LENGTH  4  operand width in bits (>=2); product width WORD = 2*WORD_LENGTH
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   Reset_Sync  in   1      synchronous clear, active-high
//   Start       in   1      request; accepted only while ready=1
//   Signed      in   1      1: two's-complement operands, 0: unsigned; sampled with Start
//   data_in_a   in   W      multiplicand, sampled on the accepting edge
//   data_in_b   in   W      multiplier, sampled on the accepting edge
//   data_out    out  2W     registered product, held until next completion
//   ready       out  1      1: idle, result valid, Start accepted
//   cout        out  1      1: product does not fit in WORD_LENGTH bits (unsigned or signed range)
// BEHAVIOUR
//   Reset (async, reset=0) and Reset_Sync=1: data_out=0, ready=1, cout=0, FSM=IDLE, acc/count=0.
//   Reset_Sync has priority over Start on the same edge; aborts any run, no result written.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: ready=1. Start=1 on edge -> latch Signed, |a|, |b|, result sign = a[W-1]^b[W-1]
//       (signed mode only), clear acc, count=0, go RUN. Start=0 -> stay.
//     RUN: ready=0. Per edge: if mult[0], acc += mcand<<count; mult>>=1; count++.
//       Leave to DONE after the WORD_LENGTH-th iteration (see CONFIGURATION).
//     DONE: ready=0. One edge: data_out <= sign ? -acc : acc (2W bits); cout computed;
//       go IDLE; ready=1 from this edge on.
//   Latency: Start accepted at edge k -> data_out valid and ready=1 after edge k+W+1 (fixed build).
//   Start while ready=0 ignored (no queueing); operand changes during a run have no effect.
//   data_out keeps previous result during a run; cout updates only with data_out.
//   Width rules: magnitudes are W-bit unsigned; -2^(W-1) magnitude = 2^(W-1) fits without loss;
//     acc is 2W bits, never overflows; (-2^(W-1))^2 = 2^(2W-2) representable.
//   cout: unsigned -> data_out[2W-1:W] != 0; signed -> data_out[2W-1:W-1] not all equal.
//   Start and Reset_Sync both 0 in IDLE: all outputs hold.
// CONFIGURATION
//   MULT_EARLY_TERM_EN defined: RUN exits to DONE as soon as the shifted multiplier is zero
//     after an iteration; RUN cycles = max(n,1), n = bit length of |b|; latency = max(n,1)+1.
//     Product, cout and handshake identical to fixed build.
//   MULT_EARLY_TERM_EN undefined: RUN always W cycles; latency fixed at W+1.
// TESTING (WORD_LENGTH=4)
//   Unsigned 15 x 15, Start 1 cycle -> data_out=0xE1 (225), cout=1, ready rises 5 edges later.
//   Signed -8 x -8 -> data_out=0x40, cout=1; signed 3 x -2 -> data_out=0xFA (-6), cout=0.
//   Signed -3 x 5 -> 0xF1 (-15), cout=1; unsigned 3 x 5 -> 0x0F, cout=0.
//   Start pulsed again at edge k+2 with new operands -> ignored, first result unchanged.
//   Reset_Sync at edge k+2 mid-run -> ready=1, data_out=0, cout=0 after that edge, no later update;
//     async reset=0 mid-run -> same values immediately, independent of clk.
//   Early term: unsigned 7 x 1 -> 0x07 after 2 edges with MULT_EARLY_TERM_EN, 5 without;
//     a x 0 -> 0x00, cout=0 after 2 edges (EN).

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add sequential multiplier with signed/unsigned mode, Start/ready handshake and overflow flag.
// Define MULT_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Reset_Sync,
    input  logic                       Start,
    input  logic                       Signed,
    input  logic [WORD_LENGTH-1:0]     data_in_a,
    input  logic [WORD_LENGTH-1:0]     data_in_b,
    output logic [2*WORD_LENGTH-1:0]   data_out,
    output logic                       ready,
    output logic                       cout
);

    localparam int W     = WORD_LENGTH;
    localparam int CNT_W = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mult_q, mult_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sign_q, sign_d;
    logic             signed_q, signed_d;
    logic [2*W-1:0]   data_out_q, data_out_d;
    logic             ready_q, ready_d;
    logic             cout_q, cout_d;
    logic             last_iter;
    logic [2*W-1:0]   product;

    // -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic is_signed);
        if (is_signed && v[W-1]) return -v;
        return v;
    endfunction

    function automatic logic overflow(input logic [2*W-1:0] p, input logic is_signed);
        if (is_signed) return !((&p[2*W-1:W-1]) || !(|p[2*W-1:W-1]));
        return |p[2*W-1:W];
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        count_d    = count_q;
        sign_d     = sign_q;
        signed_d   = signed_q;
        data_out_d = data_out_q;
        ready_d    = ready_q;
        cout_d     = cout_q;
        product    = sign_q ? -acc_q : acc_q;
        last_iter  = (count_q == CNT_W'(W - 1));
`ifdef MULT_EARLY_TERM_EN
        last_iter  = last_iter || ((mult_q >> 1) == '0);
`endif

        if (Reset_Sync) begin
            state_d    = IDLE;
            acc_d      = '0;
            mcand_d    = '0;
            mult_d     = '0;
            count_d    = '0;
            sign_d     = 1'b0;
            signed_d   = 1'b0;
            data_out_d = '0;
            ready_d    = 1'b1;
            cout_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        signed_d = Signed;
                        sign_d   = Signed & (data_in_a[W-1] ^ data_in_b[W-1]);
                        mcand_d  = magnitude(data_in_a, Signed);
                        mult_d   = magnitude(data_in_b, Signed);
                        acc_d    = '0;
                        count_d  = '0;
                        ready_d  = 1'b0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (mult_q[0]) acc_d = acc_q + ({{W{1'b0}}, mcand_q} << count_q);
                    mult_d  = mult_q >> 1;
                    count_d = count_q + CNT_W'(1);
                    if (last_iter) state_d = DONE;
                end
                DONE: begin
                    data_out_d = product;
                    cout_d     = overflow(product, signed_q);
                    ready_d    = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mult_q     <= '0;
            count_q    <= '0;
            sign_q     <= 1'b0;
            signed_q   <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b1;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            count_q    <= count_d;
            sign_q     <= sign_d;
            signed_q   <= signed_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            cout_q     <= cout_d;
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign cout     = cout_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WORD_LENGTH=4): directed table, random vs arithmetic model,
// and hand-written abort/ignore sequences. Latency expectations follow MULT_EARLY_TERM_EN when defined.
module tb_seq_shift_add_multiplier;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             Reset_Sync;
    logic             Start;
    logic             Signed;
    logic [W-1:0]     data_in_a;
    logic [W-1:0]     data_in_b;
    logic [2*W-1:0]   data_out;
    logic             ready;
    logic             cout;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] prev_out;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
        logic           c;
    } vec_t;

    vec_t vecs[14];

    seq_shift_add_multiplier #(.WORD_LENGTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Reset_Sync (Reset_Sync),
        .Start      (Start),
        .Signed     (Signed),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .data_out   (data_out),
        .ready      (ready),
        .cout       (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: product, range check and cycle count from operand magnitudes.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [2*W-1:0] p, output logic c, output int lat);
        int ia, ib, pr, mb, n;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        pr = ia * ib;
        p  = pr[2*W-1:0];
        if (s) c = (pr < -(1 << (W - 1))) || (pr > (1 << (W - 1)) - 1);
        else   c = (pr > (1 << W) - 1);
        mb = (ib < 0) ? -ib : ib;
        n  = 0;
        for (int i = 0; i < W; i++) if ((mb >> i) != 0) n = i + 1;
`ifdef MULT_EARLY_TERM_EN
        lat = ((n < 1) ? 1 : n) + 1;
`else
        lat = W + 1;
`endif
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        data_in_a = a;
        data_in_b = b;
        Signed    = s;
        Start     = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        check("ready_low_after_accept", 32'(ready), 0);
        check("data_out_held_during_run", 32'(data_out), 32'(prev_out));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic [2*W-1:0] exp_p, input logic exp_c);
        logic [2*W-1:0] mp;
        logic           mc;
        int             mlat, lat;
        model(a, b, s, mp, mc, mlat);
        start_op(a, b, s);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(mlat));
        check({name, "_product"}, 32'(data_out), 32'(exp_p));
        check({name, "_cout"}, 32'(cout), 32'(exp_c));
        prev_out = exp_p;
    endtask

    task automatic idle_hold(input string name, input logic [2*W-1:0] exp_p, input logic exp_c, input int n);
        repeat (n) @(posedge clk);
        #1;
        check({name, "_ready"}, 32'(ready), 1);
        check({name, "_data"}, 32'(data_out), 32'(exp_p));
        check({name, "_cout"}, 32'(cout), 32'(exp_c));
    endtask

    initial begin
        logic [2*W-1:0] mp;
        logic           mc;
        int             mlat, lat;
        logic [W-1:0]   ra, rb;
        logic           rs;

        vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1, 1'b1};
        vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40, 1'b1};
        vecs[2]  = '{4'h3, 4'hE, 1'b1, 8'hFA, 1'b0};
        vecs[3]  = '{4'hD, 4'h5, 1'b1, 8'hF1, 1'b1};
        vecs[4]  = '{4'h3, 4'h5, 1'b0, 8'h0F, 1'b0};
        vecs[5]  = '{4'h7, 4'h1, 1'b0, 8'h07, 1'b0};
        vecs[6]  = '{4'h9, 4'h0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{4'hA, 4'h0, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{4'h7, 4'h8, 1'b1, 8'hC8, 1'b1};
        vecs[9]  = '{4'h8, 4'h8, 1'b0, 8'h40, 1'b1};
        vecs[10] = '{4'hF, 4'hF, 1'b1, 8'h01, 1'b0};
        vecs[11] = '{4'h1, 4'hF, 1'b0, 8'h0F, 1'b0};
        vecs[12] = '{4'h7, 4'h7, 1'b1, 8'h31, 1'b1};
        vecs[13] = '{4'hF, 4'h1, 1'b1, 8'hFF, 1'b0};

        reset      = 1'b0;
        Reset_Sync = 1'b0;
        Start      = 1'b0;
        Signed     = 1'b0;
        data_in_a  = '0;
        data_in_b  = '0;
        prev_out   = '0;

        #12;
        check("reset_ready", 32'(ready), 1);
        check("reset_data_out", 32'(data_out), 0);
        check("reset_cout", 32'(cout), 0);
        @(negedge clk);
        reset = 1'b1;
        idle_hold("idle_after_reset", 8'h00, 1'b0, 3);

        for (int i = 0; i < 14; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].c);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mp, mc, mlat);
            run_check($sformatf("rand%0d", i), ra, rb, rs, mp, mc);
        end

        // Second Start two edges into a run, with new operands, must be ignored.
        model(4'hF, 4'hF, 1'b0, mp, mc, mlat);
        start_op(4'hF, 4'hF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        data_in_a = 4'h3;
        data_in_b = 4'h5;
        Signed    = 1'b1;
        Start     = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(lat);
        check("ignored_start_latency", 32'(lat + 2), 32'(mlat));
        check("ignored_start_product", 32'(data_out), 32'h0E1);
        check("ignored_start_cout", 32'(cout), 1);
        idle_hold("ignored_start_no_rerun", 8'hE1, 1'b1, 8);
        prev_out = 8'hE1;

        // Synchronous clear mid-run.
        start_op(4'hF, 4'hF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        Reset_Sync = 1'b1;
        @(posedge clk);
        #1;
        Reset_Sync = 1'b0;
        check("sync_clear_ready", 32'(ready), 1);
        check("sync_clear_data", 32'(data_out), 0);
        check("sync_clear_cout", 32'(cout), 0);
        idle_hold("sync_clear_no_update", 8'h00, 1'b0, 7);
        prev_out = 8'h00;

        // Asynchronous reset mid-run, asserted away from any clock edge.
        run_check("pre_async", 4'h8, 4'h8, 1'b1, 8'h40, 1'b1);
        start_op(4'h3, 4'h5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_ready", 32'(ready), 1);
        check("async_reset_data", 32'(data_out), 0);
        check("async_reset_cout", 32'(cout), 0);
        @(negedge clk);
        reset = 1'b1;
        idle_hold("async_reset_no_update", 8'h00, 1'b0, 7);
        prev_out = 8'h00;

        // Reset_Sync and Start on the same edge: clear wins, nothing starts.
        run_check("pre_priority", 4'hF, 4'hF, 1'b0, 8'hE1, 1'b1);
        @(negedge clk);
        data_in_a  = 4'h7;
        data_in_b  = 4'h7;
        Signed     = 1'b0;
        Start      = 1'b1;
        Reset_Sync = 1'b1;
        @(posedge clk);
        #1;
        Start      = 1'b0;
        Reset_Sync = 1'b0;
        check("priority_ready", 32'(ready), 1);
        check("priority_data", 32'(data_out), 0);
        idle_hold("priority_no_run", 8'h00, 1'b0, 7);
        prev_out = 8'h00;

        run_check("recovery", 4'h3, 4'h5, 1'b0, 8'h0F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
